// File: rtl/sync_phase_calib.sv
// Trigger-sync phase calibrator: a periodic window histograms each channel's sync pulses per clock phase and locks on the single matching bin.
// Optional SYNC_PHASE_HOLD_EN: a silent (all-zero) failing channel keeps its previous lock/phase_sel.

module sync_phase_chan #(
  parameter int NPHASE = 4,
  parameter int CW     = 8,
  parameter int PB     = 2,
  parameter int LO     = 53,
  parameter int HI     = 55
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         clr,
  input  logic                         acc,
  input  logic                         eval,
  input  logic [PB-1:0]                ph,
  input  logic                         din,
  output logic [NPHASE-1:0][CW-1:0]    hist,
  output logic                         lock,
  output logic [PB-1:0]                phase_sel
);
  int            n_hit, n_nz;
  logic [PB-1:0] hit_bin;
  logic          pass;

  always_comb begin
    n_hit   = 0;
    n_nz    = 0;
    hit_bin = '0;
    for (int b = 0; b < NPHASE; b++) begin
      if (hist[b] != '0) n_nz++;
      if (32'(hist[b]) >= LO && 32'(hist[b]) <= HI) begin
        n_hit++;
        hit_bin = PB'(b);
      end
    end
    // the in-range bin must also be the only non-empty bin
    pass = (n_hit == 1) && (n_nz == 1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hist <= '0;
    end else if (clr) begin
      hist <= '0;
    end else if (acc && din && hist[ph] != '1) begin
      hist[ph] <= hist[ph] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lock      <= 1'b0;
      phase_sel <= '0;
    end else if (eval) begin
      if (pass) begin
        lock      <= 1'b1;
        phase_sel <= hit_bin;
      end
`ifdef SYNC_PHASE_HOLD_EN
      else if (n_nz != 0) lock <= 1'b0;
`else
      else lock <= 1'b0;
`endif
    end
  end
endmodule

module sync_phase_calib #(
  parameter int NCH      = 16,
  parameter int NPHASE   = 4,
  parameter int CW       = 8,
  parameter int PERIOD   = 268435456,
  parameter int WAIT_CYC = 200,
  parameter int WIN_CYC  = 656,
  parameter int EXPECT   = 54,
  parameter int TOL      = 1,
  localparam int PB      = $clog2(NPHASE),
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [NCH-1:0]      coax_in,
  input  logic                force_start,
  output logic                window_out,
  output logic                cal_done,
  output logic [NCH-1:0]      lock,
  output logic [NCH*PB-1:0]   phase_sel,
  input  logic [CHW-1:0]      rd_ch,
  input  logic [PB-1:0]       rd_bin,
  output logic [CW-1:0]       rd_count
);
  localparam int CNTW = $clog2(PERIOD);
  localparam logic [CNTW-1:0] LAST   = CNTW'(PERIOD - 1);
  localparam logic [CNTW-1:0] WAIT_C = CNTW'(WAIT_CYC);
  localparam logic [CNTW-1:0] WIN_C  = CNTW'(WIN_CYC);
  // an all-zero channel must never lock, so the low bound never drops below 1
  localparam int LO = (EXPECT - TOL < 1) ? 1 : EXPECT - TOL;
  localparam int HI = EXPECT + TOL;

  logic [CNTW-1:0] cnt, cnt_nxt;
  logic            clr, acc, eval;
  logic [NCH-1:0][NPHASE-1:0][CW-1:0] hist;

  always_comb begin
    clr  = (cnt == '0);
    acc  = (cnt >= WAIT_C) && (cnt < WIN_C);
    eval = (cnt == WIN_C) && !force_start;
    if (force_start)      cnt_nxt = '0;
    else if (cnt == LAST) cnt_nxt = '0;
    else                  cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt        <= '0;
      window_out <= 1'b0;
      cal_done   <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      window_out <= (cnt < WIN_C);
      cal_done   <= eval;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    sync_phase_chan #(
      .NPHASE(NPHASE), .CW(CW), .PB(PB), .LO(LO), .HI(HI)
    ) u_ch (
      .clk      (clk),
      .nrst     (nrst),
      .clr      (clr),
      .acc      (acc),
      .eval     (eval),
      .ph       (cnt[PB-1:0]),
      .din      (coax_in[c]),
      .hist     (hist[c]),
      .lock     (lock[c]),
      .phase_sel(phase_sel[c*PB +: PB])
    );
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                   rd_count <= '0;
    else if (32'(rd_ch) < NCH)   rd_count <= hist[rd_ch][rd_bin];
    else                         rd_count <= '0;
  end
endmodule

// File: tb/tb_sync_phase_calib.sv
// Directed bench: table of calibration windows plus reset, abort, saturation and hold sequences.
module tb_sync_phase_calib;
  localparam int PER = 1024;
  localparam int WT  = 200;
  localparam int WN  = 656;
`ifdef SYNC_PHASE_HOLD_EN
  localparam int HOLD = 1;
`else
  localparam int HOLD = 0;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        force_start = 1'b0;
  logic [15:0] coax = '0;
  logic        window_out, cal_done;
  logic [15:0] lock;
  logic [31:0] phase_sel;
  logic [3:0]  rd_ch = '0;
  logic [1:0]  rd_bin = '0;
  logic [7:0]  rd_count;

  logic [11:0] coax_s = '0;
  logic        win_s, done_s;
  logic [11:0] lock_s;
  logic [23:0] ph_s;
  logic [3:0]  rd_ch_s = '0;
  logic [1:0]  rd_bin_s = '0;
  logic [3:0]  rd_count_s;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_phase_calib #(.NCH(16), .NPHASE(4), .CW(8), .PERIOD(PER)) dut (
    .clk(clk), .nrst(nrst), .coax_in(coax), .force_start(force_start),
    .window_out(window_out), .cal_done(cal_done), .lock(lock), .phase_sel(phase_sel),
    .rd_ch(rd_ch), .rd_bin(rd_bin), .rd_count(rd_count));

  // narrow-counter instance with 12 channels to exercise saturation and out-of-range readout
  sync_phase_calib #(.NCH(12), .NPHASE(4), .CW(4), .PERIOD(PER)) dut_s (
    .clk(clk), .nrst(nrst), .coax_in(coax_s), .force_start(force_start),
    .window_out(win_s), .cal_done(done_s), .lock(lock_s), .phase_sel(ph_s),
    .rd_ch(rd_ch_s), .rd_bin(rd_bin_s), .rd_count(rd_count_s));

  typedef struct {
    int ch; int b1; int n1; int b2; int n2;
    int lk; int ph; int cnt;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pulses(input int k, input int ch, input int b1, input int n1,
                                         input int b2, input int n2);
    logic [15:0] v;
    int occ;
    v = '0;
    if (k >= WT && k < WN) begin
      occ = (k - WT) / 4;
      if ((k % 4) == b1 && occ < n1) v[ch] = 1'b1;
      if (n2 > 0 && (k % 4) == b2 && occ < n2) v[ch] = 1'b1;
    end
    return v;
  endfunction

  // Runs the period from cycle 'start' to wrap; inputs set at posedge+1, outputs sampled at posedge+1.
  task automatic run_window(input string nm, input int start, input int ch, input int b1, input int n1,
                            input int b2, input int n2, input int lk, input int ph, input int cnt);
    rd_ch  = 4'(ch);
    rd_bin = 2'(b1);
    for (int k = start; k < PER; k++) begin
      coax     = pulses(k, ch, b1, n1, b2, n2);
      rd_bin_s = (k >= WN + 1 && k <= WN + 4) ? 2'(k - WN - 1) : 2'd0;
      rd_ch_s  = (k == WN + 5) ? 4'd13 : 4'd0;
      @(posedge clk); #1;
      if (k == 0)      chk({nm, " win_rise"}, 32'(window_out), 1);
      if (k == WN - 1) chk({nm, " win_hi"}, 32'(window_out), 1);
      if (k == WN) begin
        chk({nm, " win_lo"}, 32'(window_out), 0);
        chk({nm, " cal_done"}, 32'(cal_done), 1);
        chk({nm, " lock"}, 32'(lock[ch]), 32'(lk));
        chk({nm, " phase"}, 32'(phase_sel[ch*2 +: 2]), 32'(ph));
        chk({nm, " sat_lock"}, 32'(lock_s), 0);
      end
      if (k == WN + 1) begin
        chk({nm, " done_strobe"}, 32'(cal_done), 0);
        chk({nm, " rd_count"}, 32'(rd_count), 32'(cnt));
      end
      if (k >= WN + 1 && k <= WN + 4) chk({nm, " sat_bin"}, 32'(rd_count_s), 15);
      if (k == WN + 5) chk({nm, " rd_oor"}, 32'(rd_count_s), 0);
    end
    coax = '0;
  endtask

  initial begin
    logic seen_done;
    tbl[0] = '{ch:3, b1:2, n1:54, b2:0, n2:0, lk:1, ph:2, cnt:54};
    tbl[1] = '{ch:5, b1:1, n1:53, b2:3, n2:1, lk:0, ph:0, cnt:53};
    tbl[2] = '{ch:5, b1:1, n1:55, b2:0, n2:0, lk:1, ph:1, cnt:55};
    tbl[3] = '{ch:5, b1:1, n1:57, b2:0, n2:0, lk:0, ph:1, cnt:57};
    tbl[4] = '{ch:6, b1:0, n1:53, b2:0, n2:0, lk:1, ph:0, cnt:53};
    tbl[5] = '{ch:6, b1:3, n1:52, b2:0, n2:0, lk:0, ph:0, cnt:52};
    tbl[6] = '{ch:2, b1:0, n1:54, b2:3, n2:54, lk:0, ph:0, cnt:54};
    tbl[7] = '{ch:9, b1:1, n1:1, b2:0, n2:0, lk:0, ph:0, cnt:1};

    // reset with activity on the inputs
    coax = '1; coax_s = '1; rd_ch = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst window_out", 32'(window_out), 0);
    chk("rst cal_done", 32'(cal_done), 0);
    chk("rst lock", 32'(lock), 0);
    chk("rst phase_sel", phase_sel, 0);
    chk("rst rd_count", 32'(rd_count), 0);
    coax = '0;
    nrst = 1'b1;
    chk("post-rst window_out", 32'(window_out), 0);

    // first window also checks that only channel 3 locks
    run_window("tbl0", 0, tbl[0].ch, tbl[0].b1, tbl[0].n1, tbl[0].b2, tbl[0].n2,
               tbl[0].lk, tbl[0].ph, tbl[0].cnt);
    chk("tbl0 lock_vec", 32'(lock), 32'h0008);
    for (int i = 1; i < 8; i++)
      run_window($sformatf("tbl%0d", i), 0, tbl[i].ch, tbl[i].b1, tbl[i].n1, tbl[i].b2, tbl[i].n2,
                 tbl[i].lk, tbl[i].ph, tbl[i].cnt);

    // abort: lock ch10 at bin 3, then restart mid-accumulation of a bin-1 window
    run_window("abort_pre", 0, 10, 3, 54, 0, 0, 1, 3, 54);
    rd_ch = 4'd10; rd_bin = 2'd1;
    seen_done = 1'b0;
    for (int k = 0; k <= 400; k++) begin
      coax = pulses(k, 10, 1, 54, 0, 0);
      force_start = (k == 400);
      @(posedge clk); #1;
      if (cal_done) seen_done = 1'b1;
    end
    force_start = 1'b0; coax = '0;
    chk("abort lock", 32'(lock[10]), 1);
    chk("abort phase", 32'(phase_sel[20 +: 2]), 3);
    @(posedge clk); #1;
    if (cal_done) seen_done = 1'b1;
    @(posedge clk); #1;
    if (cal_done) seen_done = 1'b1;
    chk("abort no_done", 32'(seen_done), 0);
    chk("abort hist_clr", 32'(rd_count), 0);
    run_window("abort_post", 2, 10, 1, 54, 0, 0, 1, 1, 54);

    // hold behaviour on a silent channel
    run_window("hold_pre", 0, 7, 3, 54, 0, 0, 1, 3, 54);
    run_window("hold_quiet", 0, 7, 0, 0, 0, 0, HOLD, 3, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
